branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
// - Fetch-stage next-PC predictor: direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
// - Produces the predicted next PC carried down the pipe as PCNext, which the hazard unit checks against the resolved PC.
// - Trained from the Execute stage with resolved branch/jump outcomes.
// PARAMETERS
// - XLEN        64  PC/target width in bits
// - INDEX_BITS  4   BTB index width; 2**INDEX_BITS entries; index = PC[INDEX_BITS+1:2]
// - TAG_BITS    12  partial tag width; tag = PC[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]
// PORTS
// - clk             in   1     clock, all state updates on rising edge
// - reset_n         in   1     synchronous active-low reset
// - PCF             in   XLEN  fetch PC to predict for
// - predPCF         out  XLEN  predicted next PC
// - predHitF        out  1     BTB tag hit for PCF (debug/visibility)
// - updateE         in   1     Execute holds a resolved control-flow instruction (branch, JAL, JALR); train this cycle
// - PCE             in   XLEN  PC of the resolved instruction
// - takenE          in   1     resolved direction (1 = taken; always 1 for jumps)
// - isJumpE         in   1     instruction is JAL/JALR (unconditional)
// - targetE         in   XLEN  resolved taken target
// - mispredictE     in   1     hazard unit flagged a bad prediction this cycle (stats only)
// BEHAVIOUR
// - Lookup (combinational, same cycle):
//   - hit = valid[idx] & tag[idx]==tag(PCF).
//   - predPCF = target[idx] if hit & ctr[idx][1], else PCF+4 (XLEN modulo, wraps at 2**XLEN).
//   - No bypass: a lookup in the same cycle as an update to the same index sees the pre-update entry.
// - Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST. Saturate at 00 and 11; no wrap.
// - Update (registered; entry visible to lookups from the next cycle):
//   - Decode entry = hit on PCE at the update index (uses the same valid/tag compare as lookup).
//   - hit, takenE=1: ctr++ (saturating); target <= targetE.
//   - hit, takenE=0: ctr-- (saturating); target unchanged.
//   - miss, takenE=1: allocate / overwrite the entry: valid=1, tag=tag(PCE), target=targetE, ctr=10 (WT).
//   - miss, takenE=0: no change; not-taken branches are never allocated.
//   - isJumpE=1: counter forced to 11 (ST), regardless of hit; target <= targetE.
//   - updateE=0: no state change. Only one update per cycle.
// - Reset (reset_n=0 at clk edge): every valid bit cleared. Counters cleared to 00; targets/tags to 0.
//   - predPCF = PCF+4 and predHitF = 0 for the whole reset cycle and the cycle after.
//   - An update asserted during reset is dropped.
// - Aliasing: entries with equal index and equal partial tag alias. This is a legal misprediction; the hazard unit recovers.
// CONFIGURATION
// - BPRED_STATS_EN defined:
//   - Adds outputs statLookups, statUpdates, statMispredicts, each 32 bits.
//   - statLookups counts every non-reset cycle.
//   - statUpdates counts cycles with updateE=1.
//   - statMispredicts counts cycles with mispredictE=1.
//   - All three counters are cleared by reset and wrap modulo 2**32.
// - BPRED_STATS_EN undefined:
//   - The stat ports and counters do not exist.
//   - mispredictE is accepted but unused.
//   - Prediction behaviour is identical to the defined case.
// TESTING
// - After reset, PCF=0x1000 -> predPCF=0x1004, predHitF=0.
// - Update PCE=0x1000, takenE=1, targetE=0x2000; next cycle PCF=0x1000 -> predHitF=1, predPCF=0x2000 (ctr=WT).
// - Same entry, two not-taken updates -> ctr=SNT and predPCF=0x1004.
//   - Three taken updates then give ctr=ST, predPCF=0x2000.
//   - A fourth taken update keeps ctr at 11 (saturation).
// - Update and lookup of 0x1000 in the same cycle on an empty BTB:
//   - That cycle predPCF=0x1004.
//   - The following cycle predPCF=targetE.
// - PCF=0x1040 (same index as 0x1000, different tag) -> miss, predPCF=0x1044.
//   - A taken update at 0x1040 evicts 0x1000; a later lookup at 0x1000 misses.
// - Populate 4 entries, assert reset_n=0 for one cycle -> all lookups miss.
//   - With BPRED_STATS_EN, all stat counters read 0.
//   - Then 5 mispredictE pulses -> statMispredicts=5.

Source files
------------

// File: rtl/branch_predictor.sv
// Fetch-stage next-PC predictor: direct-mapped BTB with 2-bit saturating counters,
// trained from Execute. Optional statistics counters enabled by BPRED_STATS_EN.
module branch_predictor #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned INDEX_BITS = 4,
    parameter int unsigned TAG_BITS   = 12
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] PCF,
    output logic [XLEN-1:0] predPCF,
    output logic            predHitF,
    input  logic            updateE,
    input  logic [XLEN-1:0] PCE,
    input  logic            takenE,
    input  logic            isJumpE,
    input  logic [XLEN-1:0] targetE,
    input  logic            mispredictE
`ifdef BPRED_STATS_EN
    ,
    output logic [31:0]     statLookups,
    output logic [31:0]     statUpdates,
    output logic [31:0]     statMispredicts
`endif
);

    localparam int unsigned ENTRIES = 2 ** INDEX_BITS;
    localparam int unsigned IDX_LO  = 2;
    localparam int unsigned IDX_HI  = INDEX_BITS + 1;
    localparam int unsigned TAG_LO  = INDEX_BITS + 2;
    localparam int unsigned TAG_HI  = INDEX_BITS + TAG_BITS + 1;

    localparam logic [1:0] CTR_WT = 2'b10;
    localparam logic [1:0] CTR_ST = 2'b11;

    logic [ENTRIES-1:0]  valid_q, valid_d;
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [TAG_BITS-1:0] tag_d    [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];
    logic [XLEN-1:0]     target_d [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];
    logic [1:0]          ctr_d    [ENTRIES];

    logic [INDEX_BITS-1:0] idx_f, idx_e;
    logic [TAG_BITS-1:0]   tag_f, tag_e;
    logic                  hit_f, hit_e;

    assign idx_f = PCF[IDX_HI:IDX_LO];
    assign tag_f = PCF[TAG_HI:TAG_LO];
    assign idx_e = PCE[IDX_HI:IDX_LO];
    assign tag_e = PCE[TAG_HI:TAG_LO];

    // Lookup; forced to miss while reset is asserted since the arrays still hold old state.
    always_comb begin
        hit_f    = reset_n && valid_q[idx_f] && (tag_q[idx_f] == tag_f);
        predHitF = hit_f;
        predPCF  = (hit_f && ctr_q[idx_f][1]) ? target_q[idx_f] : PCF + XLEN'(4);
    end

    assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

    // Training from Execute; jumps always (re)allocate as strongly taken.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (updateE) begin
            if (isJumpE) begin
                valid_d[idx_e]  = 1'b1;
                tag_d[idx_e]    = tag_e;
                target_d[idx_e] = targetE;
                ctr_d[idx_e]    = CTR_ST;
            end else if (hit_e) begin
                if (takenE) begin
                    target_d[idx_e] = targetE;
                    if (ctr_q[idx_e] != CTR_ST) begin
                        ctr_d[idx_e] = ctr_q[idx_e] + 2'd1;
                    end
                end else if (ctr_q[idx_e] != 2'b00) begin
                    ctr_d[idx_e] = ctr_q[idx_e] - 2'd1;
                end
            end else if (takenE) begin
                valid_d[idx_e]  = 1'b1;
                tag_d[idx_e]    = tag_e;
                target_d[idx_e] = targetE;
                ctr_d[idx_e]    = CTR_WT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q  <= '0;
            tag_q    <= '{default: '0};
            target_q <= '{default: '0};
            ctr_q    <= '{default: '0};
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

`ifdef BPRED_STATS_EN
    logic [31:0] stat_lookups_q, stat_lookups_d;
    logic [31:0] stat_updates_q, stat_updates_d;
    logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

    always_comb begin
        stat_lookups_d     = stat_lookups_q + 32'd1;
        stat_updates_d     = stat_updates_q + 32'(updateE);
        stat_mispredicts_d = stat_mispredicts_q + 32'(mispredictE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_lookups_q     <= '0;
            stat_updates_q     <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_lookups_q     <= stat_lookups_d;
            stat_updates_q     <= stat_updates_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign statLookups     = stat_lookups_q;
    assign statUpdates     = stat_updates_q;
    assign statMispredicts = stat_mispredicts_q;

    logic unused_c;
    assign unused_c = ^{PCE[1:0], PCE[XLEN-1:TAG_HI+1]};
`else
    logic unused_c;
    assign unused_c = ^{PCE[1:0], PCE[XLEN-1:TAG_HI+1], mispredictE};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: expected lookups are queued as each step is
// driven and popped when the combinational prediction is sampled.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] PCF, predPCF, PCE, targetE;
    logic        predHitF, updateE, takenE, isJumpE, mispredictE;
`ifdef BPRED_STATS_EN
    logic [31:0] statLookups, statUpdates, statMispredicts;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    typedef struct {
        string       tag;
        logic [63:0] pc;
        logic        hit;
    } exp_t;

    exp_t sb_q[$];

    branch_predictor dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .PCF         (PCF),
        .predPCF     (predPCF),
        .predHitF    (predHitF),
        .updateE     (updateE),
        .PCE         (PCE),
        .takenE      (takenE),
        .isJumpE     (isJumpE),
        .targetE     (targetE),
        .mispredictE (mispredictE)
`ifdef BPRED_STATS_EN
        ,
        .statLookups     (statLookups),
        .statUpdates     (statUpdates),
        .statMispredicts (statMispredicts)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // One cycle: drive at negedge, queue expectation, check lookup before the next posedge.
    task automatic step(input string tag, input logic rst, input logic [63:0] pcf,
                        input logic upd, input logic [63:0] pce, input logic tkn,
                        input logic jmp, input logic [63:0] tgt, input logic misp,
                        input logic [63:0] exp_pc, input logic exp_hit);
        exp_t e;
        @(negedge clk);
        reset_n     = rst;
        PCF         = pcf;
        updateE     = upd;
        PCE         = pce;
        takenE      = tkn;
        isJumpE     = jmp;
        targetE     = tgt;
        mispredictE = misp;
        sb_q.push_back('{tag, exp_pc, exp_hit});
        #1;
        n_asserts++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            n_asserts++;
            assert (predPCF === e.pc) else begin
                n_fail++;
                $error("FAIL %s predPCF observed=%h expected=%h", e.tag, predPCF, e.pc);
            end
            assert (predHitF === e.hit) else begin
                n_fail++;
                $error("FAIL %s predHitF observed=%b expected=%b", e.tag, predHitF, e.hit);
            end
        end
    endtask

    task automatic look(input string tag, input logic [63:0] pcf,
                        input logic [63:0] exp_pc, input logic exp_hit);
        step(tag, 1'b1, pcf, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, exp_pc, exp_hit);
    endtask

    task automatic upd_look(input string tag, input logic [63:0] pcf, input logic [63:0] pce,
                            input logic tkn, input logic jmp, input logic [63:0] tgt,
                            input logic [63:0] exp_pc, input logic exp_hit);
        step(tag, 1'b1, pcf, 1'b1, pce, tkn, jmp, tgt, 1'b0, exp_pc, exp_hit);
    endtask

    initial begin
        reset_n = 1'b0; PCF = '0; updateE = 1'b0; PCE = '0; takenE = 1'b0;
        isJumpE = 1'b0; targetE = '0; mispredictE = 1'b0;

        // Reset; an update offered during reset must be dropped.
        step("rst0", 1'b0, 64'h1000, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h1004, 1'b0);
        step("rst1", 1'b0, 64'h1000, 1'b1, 64'h1000, 1'b1, 1'b0, 64'h2000, 1'b0, 64'h1004, 1'b0);
        look("post_rst", 64'h1000, 64'h1004, 1'b0);

        // Allocate as WT; same-cycle lookup sees the old (empty) entry.
        upd_look("same_cyc", 64'h1000, 64'h1000, 1'b1, 1'b0, 64'h2000, 64'h1004, 1'b0);
        look("alloc_wt", 64'h1000, 64'h2000, 1'b1);

        // WT -> WNT -> SNT
        upd_look("nt1", 64'h1000, 64'h1000, 1'b0, 1'b0, 64'h0, 64'h2000, 1'b1);
        upd_look("nt2", 64'h1000, 64'h1000, 1'b0, 1'b0, 64'h0, 64'h1004, 1'b1);
        // SNT -> WNT -> WT -> ST -> ST
        upd_look("t1", 64'h1000, 64'h1000, 1'b1, 1'b0, 64'h2000, 64'h1004, 1'b1);
        upd_look("t2", 64'h1000, 64'h1000, 1'b1, 1'b0, 64'h2000, 64'h1004, 1'b1);
        upd_look("t3", 64'h1000, 64'h1000, 1'b1, 1'b0, 64'h2000, 64'h2000, 1'b1);
        upd_look("t4_sat", 64'h1000, 64'h1000, 1'b1, 1'b0, 64'h2000, 64'h2000, 1'b1);
        // ST stays ST (no wrap): one not-taken leaves WT, still predicting taken.
        upd_look("st_nt", 64'h1000, 64'h1000, 1'b0, 1'b0, 64'h0, 64'h2000, 1'b1);
        look("wt_after_st", 64'h1000, 64'h2000, 1'b1);
        upd_look("wt_nt", 64'h1000, 64'h1000, 1'b0, 1'b0, 64'h0, 64'h2000, 1'b1);
        look("wnt", 64'h1000, 64'h1004, 1'b1);
        // Saturate at SNT: extra not-taken must not wrap to ST.
        upd_look("wnt_nt", 64'h1000, 64'h1000, 1'b0, 1'b0, 64'h0, 64'h1004, 1'b1);
        upd_look("snt_nt", 64'h1000, 64'h1000, 1'b0, 1'b0, 64'h0, 64'h1004, 1'b1);
        look("snt_sat", 64'h1000, 64'h1004, 1'b1);

        // Alias index, different tag: miss, then eviction.
        look("alias_miss", 64'h1040, 64'h1044, 1'b0);
        upd_look("evict", 64'h1040, 64'h1040, 1'b1, 1'b0, 64'h3000, 64'h1044, 1'b0);
        look("evict_hit", 64'h1040, 64'h3000, 1'b1);
        look("evicted", 64'h1000, 64'h1004, 1'b0);

        // Not-taken miss does not allocate.
        upd_look("nt_miss", 64'h1040, 64'h1080, 1'b0, 1'b0, 64'h4000, 64'h3000, 1'b1);
        look("nt_no_alloc", 64'h1080, 64'h1084, 1'b0);
        look("nt_kept", 64'h1040, 64'h3000, 1'b1);

        // Jump allocates as ST: one not-taken still predicts taken.
        upd_look("jmp", 64'h2010, 64'h2010, 1'b1, 1'b1, 64'h5000, 64'h2014, 1'b0);
        look("jmp_hit", 64'h2010, 64'h5000, 1'b1);
        upd_look("jmp_nt", 64'h2010, 64'h2010, 1'b0, 1'b0, 64'h0, 64'h5000, 1'b1);
        look("jmp_st", 64'h2010, 64'h5000, 1'b1);

        // PC+4 wraps modulo 2**64.
        look("wrap", 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1'b0);

        // Four live entries, then a single reset cycle clears them all.
        upd_look("pop3", 64'h0, 64'h1008, 1'b1, 1'b0, 64'h6000, 64'h4, 1'b0);
        upd_look("pop4", 64'h0, 64'h100C, 1'b1, 1'b0, 64'h7000, 64'h4, 1'b0);
        look("pop_chk", 64'h100C, 64'h7000, 1'b1);
        step("rst_cyc", 1'b0, 64'h1040, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h1044, 1'b0);
        look("rst_a", 64'h2010, 64'h2014, 1'b0);
`ifdef BPRED_STATS_EN
        n_asserts++;
        assert (statLookups === 32'd0 && statUpdates === 32'd0 && statMispredicts === 32'd0) else begin
            n_fail++;
            $error("FAIL stats_rst observed=%0d/%0d/%0d expected=0/0/0",
                   statLookups, statUpdates, statMispredicts);
        end
`endif
        look("rst_b", 64'h1008, 64'h100C, 1'b0);
        look("rst_c", 64'h100C, 64'h1010, 1'b0);
        look("rst_d", 64'h1000, 64'h1004, 1'b0);

`ifdef BPRED_STATS_EN
        for (int i = 0; i < 5; i++) begin
            step("misp", 1'b1, 64'h1040, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b1, 64'h1044, 1'b0);
        end
        @(negedge clk);
        mispredictE = 1'b0;
        #1;
        n_asserts++;
        assert (statMispredicts === 32'd5) else begin
            n_fail++;
            $error("FAIL stats_misp observed=%0d expected=5", statMispredicts);
        end
        n_asserts++;
        assert (statLookups === 32'd9) else begin
            n_fail++;
            $error("FAIL stats_lookups observed=%0d expected=9", statLookups);
        end
        n_asserts++;
        assert (statUpdates === 32'd0) else begin
            n_fail++;
            $error("FAIL stats_updates observed=%0d expected=0", statUpdates);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
